// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with skid-buffered stall and branch redirect squash
module if_fetch #(
  parameter int unsigned            ADDR_WIDTH   = 14,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [31:0]            NOP_WORD     = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  output logic [31:0]           instruction_out,
  output logic [ADDR_WIDTH-1:0] return_addr_out,
  output logic                  take_branch_addr_out
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] fetch_pc, pend_pc;
  logic                  data_valid, tgt_flag;
  logic [31:0]           skid;
  logic                  squash;
  // outputs follow the sync memory directly; squash covers reset, redirect and boot bubbles
  always_comb begin
    squash               = reset || branch_valid || state == BOOT;
    imem_en              = !reset && (branch_valid || !stall);
    imem_addr            = branch_valid ? branch_target : fetch_pc;
    instruction_out      = squash ? NOP_WORD : state == HOLD ? skid : data_valid ? imem_data : NOP_WORD;
    return_addr_out      = (reset || state == BOOT) ? '0 : pend_pc + ADDR_WIDTH'(1);
    take_branch_addr_out = squash ? 1'b0 : state == HOLD ? tgt_flag : tgt_flag && data_valid;
  end
  // pc sequencing and stall capture; redirect outranks stall, an issue moves to RUN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      fetch_pc   <= RESET_VECTOR;
      pend_pc    <= '0;
      data_valid <= 1'b0;
      skid       <= NOP_WORD;
      tgt_flag   <= 1'b0;
    end else if (branch_valid) begin
      state      <= RUN;
      pend_pc    <= branch_target;
      fetch_pc   <= branch_target + ADDR_WIDTH'(1);
      data_valid <= 1'b1;
      tgt_flag   <= 1'b1;
      skid       <= NOP_WORD;
    end else if (stall) begin
      if (state == RUN && data_valid) begin
        skid  <= imem_data;
        state <= HOLD;
      end else if (state == RUN) begin
        data_valid <= 1'b0;
      end
    end else begin
      state      <= RUN;
      pend_pc    <= fetch_pc;
      fetch_pc   <= fetch_pc + ADDR_WIDTH'(1);
      data_valid <= 1'b1;
      tgt_flag   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vectors for fetch, stall, redirect, wrap and async reset
module tb_if_fetch;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic [13:0] branch_target = '0;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic [31:0] instruction_out;
  logic [13:0] return_addr_out;
  logic        take_branch_addr_out;
  int          vecs = 0;
  int          errs = 0;
  typedef struct packed {
    logic        st;
    logic        bv;
    logic [13:0] bt;
    logic        en;
    logic [13:0] addr;
    logic [31:0] ins;
    logic [13:0] ret;
    logic        tb;
  } vec_t;
  if_fetch dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .instruction_out(instruction_out),
    .return_addr_out(return_addr_out), .take_branch_addr_out(take_branch_addr_out)
  );
  always #5 clock = ~clock;
  // program memory holding addr*4 at every word, one-cycle read latency
  always @(posedge clock) if (imem_en) imem_data <= {16'h0000, imem_addr, 2'b00};
  wire [61:0] obs = {imem_en, imem_addr, instruction_out, return_addr_out, take_branch_addr_out};
  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      vecs++;
      if (obs !== {1'b1 & 1'b0, 14'h0000, 32'h0, 14'h0000, 1'b0}) begin
        errs++;
        $display("FAIL reset[%0d] got %h want %h", i, obs, {1'b0, 14'h0000, 32'h0, 14'h0000, 1'b0});
      end
    end
  endtask
  task automatic test_fetch;
    vec_t v[6] = '{
      '{0,0,14'h0, 1,14'h0,32'd0, 14'h0,0},
      '{0,0,14'h0, 1,14'h1,32'd0, 14'h1,0},
      '{0,0,14'h0, 1,14'h2,32'd4, 14'h2,0},
      '{0,0,14'h0, 1,14'h3,32'd8, 14'h3,0},
      '{0,0,14'h0, 1,14'h4,32'd12,14'h4,0},
      '{0,0,14'h0, 1,14'h5,32'd16,14'h5,0}};
    foreach (v[i]) begin
      @(negedge clock);
      reset = 1'b0; stall = v[i].st; branch_valid = v[i].bv; branch_target = v[i].bt;
      #1;
      vecs++;
      if (obs !== {v[i].en, v[i].addr, v[i].ins, v[i].ret, v[i].tb}) begin
        errs++;
        $display("FAIL fetch[%0d] got %h want %h", i, obs, {v[i].en, v[i].addr, v[i].ins, v[i].ret, v[i].tb});
      end
    end
  endtask
  task automatic test_stall;
    vec_t v[5] = '{
      '{1,0,14'h0, 0,14'h6,32'd20,14'h6,0},
      '{1,0,14'h0, 0,14'h6,32'd20,14'h6,0},
      '{1,0,14'h0, 0,14'h6,32'd20,14'h6,0},
      '{0,0,14'h0, 1,14'h6,32'd20,14'h6,0},
      '{0,0,14'h0, 1,14'h7,32'd24,14'h7,0}};
    foreach (v[i]) begin
      @(negedge clock);
      stall = v[i].st; branch_valid = v[i].bv; branch_target = v[i].bt;
      #1;
      vecs++;
      if (obs !== {v[i].en, v[i].addr, v[i].ins, v[i].ret, v[i].tb}) begin
        errs++;
        $display("FAIL stall[%0d] got %h want %h", i, obs, {v[i].en, v[i].addr, v[i].ins, v[i].ret, v[i].tb});
      end
    end
  endtask
  task automatic test_branch;
    vec_t v[3] = '{
      '{0,1,14'h100, 1,14'h100,32'h0,   14'h008,0},
      '{0,0,14'h0,   1,14'h101,32'h400, 14'h101,1},
      '{0,0,14'h0,   1,14'h102,32'h404, 14'h102,0}};
    foreach (v[i]) begin
      @(negedge clock);
      stall = v[i].st; branch_valid = v[i].bv; branch_target = v[i].bt;
      #1;
      vecs++;
      if (obs !== {v[i].en, v[i].addr, v[i].ins, v[i].ret, v[i].tb}) begin
        errs++;
        $display("FAIL branch[%0d] got %h want %h", i, obs, {v[i].en, v[i].addr, v[i].ins, v[i].ret, v[i].tb});
      end
    end
  endtask
  task automatic test_hold_branch;
    vec_t v[6] = '{
      '{1,0,14'h0,   0,14'h103,32'h408, 14'h103,0},
      '{1,1,14'h200, 1,14'h200,32'h0,   14'h103,0},
      '{1,0,14'h0,   0,14'h201,32'h800, 14'h201,1},
      '{1,0,14'h0,   0,14'h201,32'h800, 14'h201,1},
      '{0,0,14'h0,   1,14'h201,32'h800, 14'h201,1},
      '{0,0,14'h0,   1,14'h202,32'h804, 14'h202,0}};
    foreach (v[i]) begin
      @(negedge clock);
      stall = v[i].st; branch_valid = v[i].bv; branch_target = v[i].bt;
      #1;
      vecs++;
      if (obs !== {v[i].en, v[i].addr, v[i].ins, v[i].ret, v[i].tb}) begin
        errs++;
        $display("FAIL hold_branch[%0d] got %h want %h", i, obs, {v[i].en, v[i].addr, v[i].ins, v[i].ret, v[i].tb});
      end
    end
  endtask
  task automatic test_wrap;
    vec_t v[4] = '{
      '{0,1,14'h3FFE, 1,14'h3FFE,32'h0,    14'h0203,0},
      '{0,0,14'h0,    1,14'h3FFF,32'hFFF8, 14'h3FFF,1},
      '{0,0,14'h0,    1,14'h0000,32'hFFFC, 14'h0000,0},
      '{0,0,14'h0,    1,14'h0001,32'h0,    14'h0001,0}};
    foreach (v[i]) begin
      @(negedge clock);
      stall = v[i].st; branch_valid = v[i].bv; branch_target = v[i].bt;
      #1;
      vecs++;
      if (obs !== {v[i].en, v[i].addr, v[i].ins, v[i].ret, v[i].tb}) begin
        errs++;
        $display("FAIL wrap[%0d] got %h want %h", i, obs, {v[i].en, v[i].addr, v[i].ins, v[i].ret, v[i].tb});
      end
    end
  endtask
  task automatic test_reset_mid_stall;
    vec_t v[5] = '{
      '{1,0,14'h0, 0,14'h2,32'd4, 14'h2,0},
      '{1,0,14'h0, 0,14'h2,32'd4, 14'h2,0},
      '{0,0,14'h0, 1,14'h0,32'd0, 14'h0,0},
      '{0,0,14'h0, 1,14'h1,32'd0, 14'h1,0},
      '{0,0,14'h0, 1,14'h2,32'd4, 14'h2,0}};
    foreach (v[i]) begin
      @(negedge clock);
      if (i == 2) reset = 1'b0;
      stall = v[i].st; branch_valid = v[i].bv; branch_target = v[i].bt;
      #1;
      vecs++;
      if (obs !== {v[i].en, v[i].addr, v[i].ins, v[i].ret, v[i].tb}) begin
        errs++;
        $display("FAIL rst_stall[%0d] got %h want %h", i, obs, {v[i].en, v[i].addr, v[i].ins, v[i].ret, v[i].tb});
      end
      if (i == 1) begin
        #2 reset = 1'b1;
        #1;
        vecs++;
        if (obs !== {1'b0, 14'h0, 32'h0, 14'h0, 1'b0}) begin
          errs++;
          $display("FAIL rst_async got %h want %h", obs, {1'b0, 14'h0, 32'h0, 14'h0, 1'b0});
        end
        @(posedge clock);
        #1;
        vecs++;
        if (obs !== {1'b0, 14'h0, 32'h0, 14'h0, 1'b0}) begin
          errs++;
          $display("FAIL rst_held got %h want %h", obs, {1'b0, 14'h0, 32'h0, 14'h0, 1'b0});
        end
      end
    end
  endtask
  initial begin
    test_reset;
    test_fetch;
    test_stall;
    test_branch;
    test_hold_branch;
    test_wrap;
    test_reset_mid_stall;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
